fifo_share_ctrl: RTL and testbench
==================================

Name: fifo_share_ctrl

Overview:
- Controller that shares one fifo instance between NUM_REQ producers and one consumer.
- Write side: round-robin arbitration with burst lock. The winner's data is tagged with its source ID and written into the FIFO.
- Read side: sequences FIFO reads into a registered valid/ready output stage, accounting for the FIFO's registered rdata.
- Sits between the request sources and the shared command FIFO.

Parameters:
- NUM_REQ, 4, number of producers (power of 2, ≥2)
- ID_W, 2, source tag width = log2(NUM_REQ)
- DATA_W, 6, payload width per producer
- FIFO_W, 8, FIFO word width; must equal ID_W+DATA_W
- MAX_BURST, 4, max consecutive grants to one owner before forced release (≥1)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  producer i has a word
- req_last  in  NUM_REQ  word from producer i ends its burst
- req_data  in  NUM_REQ*DATA_W  producer i payload, slice i
- req_grant  out  NUM_REQ  one-hot, combinational; word i accepted this cycle
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_wdata  out  FIFO_W  {id, payload}, id in MSBs
- fifo_full  in  1  from FIFO
- fifo_empty  in  1  from FIFO
- fifo_rd_en  out  1  to FIFO rd_en
- fifo_rdata  in  FIFO_W  from FIFO; valid the cycle after rd_en
- fifo_error  in  1  from FIFO
- out_ready  in  1  consumer accepts
- out_valid  out  1  registered output word valid
- out_id  out  ID_W  source tag of output word
- out_data  out  DATA_W  payload of output word
- err_sticky  out  1  latched FIFO error

Behaviour:
- Reset (sync, rst=1 at edge), regardless of current state:
  - wr_state=WR_IDLE, rr_ptr=0, burst_cnt=0, rd_pending=0
  - out_valid=0, out_id=0, out_data=0, err_sticky=0
  - req_grant, fifo_wr_en and fifo_rd_en are 0 while rst=1
- Write FSM WR_IDLE:
  - Candidate = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - If a candidate exists and fifo_full=0: req_grant[i]=1, fifo_wr_en=1, fifo_wdata={i, req_data slice i}.
  - On that grant: if req_last[i]=1 or MAX_BURST=1, rr_ptr<=i+1 and stay in WR_IDLE. Otherwise owner<=i, burst_cnt<=1, go to WR_LOCK.
- Write FSM WR_LOCK (only owner is eligible):
  - If req_valid[owner]=1 and fifo_full=0: grant owner and burst_cnt<=burst_cnt+1.
  - Exit to WR_IDLE with rr_ptr<=owner+1 when the granted word has req_last=1, or when burst_cnt+1==MAX_BURST (forced release).
  - If req_valid[owner]=0: no grant; exit to WR_IDLE with rr_ptr<=owner+1 the same cycle.
- fifo_full=1:
  - No grant, no wr_en.
  - State, owner, burst_cnt and rr_ptr hold; stall cycles do not count toward the burst.
- Write is never issued while fifo_full=1. A read in the same cycle does not free a slot for that cycle.
- Read sequencing:
  - fifo_rd_en = !fifo_empty && !rd_pending && (!out_valid || out_ready).
  - rd_pending <= fifo_rd_en.
  - When rd_pending=1: out_valid<=1, out_id<=fifo_rdata[FIFO_W-1:DATA_W], out_data<=fifo_rdata[DATA_W-1:0].
  - Else if out_valid && out_ready: out_valid<=0.
  - Latency: rd_en in cycle t gives out_valid in cycle t+2. Max throughput is 1 word per 2 cycles.
  - While out_valid=1 and out_ready=0: out_id/out_data are stable and no rd_en is issued.
- Write and read sides are independent and may both be active in the same cycle.
- err_sticky <= err_sticky | fifo_error; cleared only by rst.

Test Plan:
1. Reset: hold rst 2 cycles with req_valid=4'hF and fifo_empty=0 -> grant, wr_en and rd_en are 0; after release out_valid=0, err_sticky=0, first grant goes to req0.
2. Round robin: req_valid=4'hF, req_last=4'hF, fifo_full=0, payload_i=i+8 -> grants 0,1,2,3,0 on consecutive cycles; fifo_wdata=8'h08, 8'h49, 8'h8A, 8'hCB, 8'h08.
3. Burst lock and forced release (MAX_BURST=4): req2 streams 6 words with last on the 6th, req0 valid, rr_ptr=2 -> grants 2,2,2,2,0,2,2; the second req2 grant sequence ends on last.
4. Backpressure: fifo_full=1 for 5 cycles mid-burst of req1 (burst_cnt=2) -> no grant or wr_en for 5 cycles; after release, req1 is granted and the burst ends after 2 more grants.
5. Read path: FIFO holds 8'h4A then 8'h85, out_ready=1 -> out_valid in cycle t+2 with id=1, data=0x0A, then at t+4 with id=2, data=0x05. With out_ready=0 at t+2, out holds and rd_en stays 0 until ready.
6. Error and mid-burst reset: fifo_error pulses 1 cycle -> err_sticky=1 and stays 1. Then rst in WR_LOCK -> next cycle WR_IDLE, err_sticky=0, grant arbitration restarts at req0.

Source files
------------

// File: rtl/fifo_share_ctrl.sv
// Shares one command FIFO between NUM_REQ producers and a single consumer:
// round-robin write arbitration with burst lock, plus a registered read/output stage.
module fifo_share_ctrl #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned DATA_W    = 6,
  parameter int unsigned FIFO_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic                      fifo_wr_en,
  output logic [FIFO_W-1:0]         fifo_wdata,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  output logic                      fifo_rd_en,
  input  logic [FIFO_W-1:0]         fifo_rdata,
  input  logic                      fifo_error,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [ID_W-1:0]           out_id,
  output logic [DATA_W-1:0]         out_data,
  output logic                      err_sticky
);

  localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
  localparam logic [BurstW:0] MaxBurst = (BurstW + 1)'(MAX_BURST);

  typedef enum logic [0:0] {WrIdle, WrLock} wr_state_e;

  wr_state_e           wr_state_q, wr_state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [BurstW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [BurstW:0]     burst_inc;
  logic                rd_pending_q, rd_pending_d;
  logic                out_valid_q, out_valid_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                err_sticky_q, err_sticky_d;

  logic                cand_found;
  logic [ID_W-1:0]     cand_idx;
  logic                grant_vld;
  logic [ID_W-1:0]     grant_idx;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!cand_found && req_valid[rr_ptr_q + ID_W'(k)]) begin
        cand_found = 1'b1;
        cand_idx   = rr_ptr_q + ID_W'(k);
      end
    end
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    grant_vld   = 1'b0;
    grant_idx   = cand_idx;
    burst_inc   = {1'b0, burst_cnt_q} + 1'b1;
    unique case (wr_state_q)
      WrIdle: begin
        if (cand_found && !fifo_full) begin
          grant_vld = 1'b1;
          if (req_last[cand_idx] || MAX_BURST == 1) begin
            rr_ptr_d = cand_idx + 1'b1;
          end else begin
            owner_d     = cand_idx;
            burst_cnt_d = BurstW'(1);
            wr_state_d  = WrLock;
          end
        end
      end
      WrLock: begin
        grant_idx = owner_q;
        // A full FIFO freezes the lock; stall cycles do not count toward the burst.
        if (!fifo_full) begin
          if (req_valid[owner_q]) begin
            grant_vld   = 1'b1;
            burst_cnt_d = burst_inc[BurstW-1:0];
            if (req_last[owner_q] || burst_inc == MaxBurst) begin
              wr_state_d = WrIdle;
              rr_ptr_d   = owner_q + 1'b1;
            end
          end else begin
            wr_state_d = WrIdle;
            rr_ptr_d   = owner_q + 1'b1;
          end
        end
      end
      default: wr_state_d = WrIdle;
    endcase
  end

  always_comb begin
    req_grant  = '0;
    fifo_wr_en = 1'b0;
    fifo_wdata = '0;
    if (grant_vld && !rst) begin
      req_grant[grant_idx] = 1'b1;
      fifo_wr_en           = 1'b1;
      fifo_wdata           = {grant_idx, req_data[int'(grant_idx) * DATA_W +: DATA_W]};
    end
  end

  // FIFO rdata lags rd_en by a cycle, so only one read is kept in flight.
  assign fifo_rd_en = !rst && !fifo_empty && !rd_pending_q && (!out_valid_q || out_ready);

  always_comb begin
    rd_pending_d = fifo_rd_en;
    out_valid_d  = out_valid_q;
    out_id_d     = out_id_q;
    out_data_d   = out_data_q;
    err_sticky_d = err_sticky_q | fifo_error;
    if (rd_pending_q) begin
      out_valid_d = 1'b1;
      out_id_d    = fifo_rdata[FIFO_W-1:DATA_W];
      out_data_d  = fifo_rdata[DATA_W-1:0];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q   <= WrIdle;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      burst_cnt_q  <= '0;
      rd_pending_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_id_q     <= '0;
      out_data_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pending_q <= rd_pending_d;
      out_valid_q  <= out_valid_d;
      out_id_q     <= out_id_d;
      out_data_q   <= out_data_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_id     = out_id_q;
  assign out_data   = out_data_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// Bench for fifo_share_ctrl: table-driven write-side vectors, a queue model of the shared
// FIFO, and a scoreboard that checks every word leaving the output stage.
module tb_fifo_share_ctrl;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned DATA_W  = 6;
  localparam int unsigned FIFO_W  = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_grant;
  logic                      fifo_wr_en;
  logic [FIFO_W-1:0]         fifo_wdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_rd_en;
  logic [FIFO_W-1:0]         fifo_rdata;
  logic                      fifo_error;
  logic                      out_ready;
  logic                      out_valid;
  logic [ID_W-1:0]           out_id;
  logic [DATA_W-1:0]         out_data;
  logic                      err_sticky;

  fifo_share_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_data   (req_data),
    .req_grant  (req_grant),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .fifo_error (fifo_error),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_id     (out_id),
    .out_data   (out_data),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic       full;
    logic [3:0] exp_grant;
    logic [7:0] exp_wdata;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] mem[$];
  logic [7:0] exp_q[$];
  logic       pend_pop;
  logic       pend_push;
  logic [7:0] pend_wdata;
  int         checks = 0;
  int         errors = 0;

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic f, logic [3:0] g,
                              logic [7:0] w);
    vec_t r;
    r.valid     = v;
    r.last      = l;
    r.full      = f;
    r.exp_grant = g;
    r.exp_wdata = w;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Negedge: sample DUT requests to the model FIFO and score any output handshake.
  task automatic half();
    logic [7:0] e;
    @(negedge clk);
    pend_pop   = fifo_rd_en;
    pend_push  = fifo_wr_en;
    pend_wdata = fifo_wdata;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=%0h expected=none", {out_id, out_data});
      end else begin
        e = exp_q.pop_front();
        chk("sb_word", 32'({out_id, out_data}), 32'(e));
      end
    end
  endtask

  // Just after posedge: model FIFO registers rdata on a read and accepts a write.
  task automatic step_edge();
    @(posedge clk);
    #1;
    if (pend_pop) fifo_rdata = mem.pop_front();
    if (pend_push) begin
      mem.push_back(pend_wdata);
      exp_q.push_back(pend_wdata);
    end
    fifo_empty = (mem.size() == 0);
    pend_pop   = 1'b0;
    pend_push  = 1'b0;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    req_valid = v.valid;
    req_last  = v.last;
    fifo_full = v.full;
    half();
    chk($sformatf("vec%0d_grant", idx), 32'(req_grant), 32'(v.exp_grant));
    chk($sformatf("vec%0d_wr_en", idx), 32'(fifo_wr_en), 32'(|v.exp_grant));
    if (v.exp_grant != 4'h0) begin
      chk($sformatf("vec%0d_wdata", idx), 32'(fifo_wdata), 32'(v.exp_wdata));
    end
    step_edge();
  endtask

  task automatic drain(input string name);
    logic done;
    done      = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      half();
      done = (exp_q.size() == 0) && !pend_push;
      step_edge();
    end
    chk(name, 32'(done), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 4'hF;
    req_last   = 4'hF;
    fifo_full  = 1'b0;
    fifo_error = 1'b0;
    out_ready  = 1'b1;
    fifo_rdata = '0;
    pend_pop   = 1'b0;
    pend_push  = 1'b0;
    pend_wdata = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) req_data[i*DATA_W +: DATA_W] = DATA_W'(i + 8);
    mem.push_back(8'h4A);
    exp_q.push_back(8'h4A);
    fifo_empty = 1'b0;

    // Round robin, then burst lock with forced release, backpressure, owner drop, full idle.
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 4'h1, 8'h08));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 4'h2, 8'h49));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 4'h4, 8'h8A));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 4'h8, 8'hCB));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 4'h1, 8'h08));
    vecs.push_back(mk(4'h2, 4'hF, 1'b0, 4'h2, 8'h49));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(4'h5, 4'h1, 1'b0, 4'h4, 8'h8A));
    vecs.push_back(mk(4'h5, 4'h1, 1'b0, 4'h1, 8'h08));
    vecs.push_back(mk(4'h5, 4'h1, 1'b0, 4'h4, 8'h8A));
    vecs.push_back(mk(4'h5, 4'h5, 1'b0, 4'h4, 8'h8A));
    vecs.push_back(mk(4'h2, 4'h0, 1'b0, 4'h2, 8'h49));
    vecs.push_back(mk(4'h2, 4'h0, 1'b0, 4'h2, 8'h49));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(4'h2, 4'h0, 1'b1, 4'h0, 8'h00));
    vecs.push_back(mk(4'h2, 4'h0, 1'b0, 4'h2, 8'h49));
    vecs.push_back(mk(4'h2, 4'h0, 1'b0, 4'h2, 8'h49));
    vecs.push_back(mk(4'h3, 4'h1, 1'b0, 4'h1, 8'h08));
    vecs.push_back(mk(4'h8, 4'h0, 1'b0, 4'h8, 8'hCB));
    vecs.push_back(mk(4'h1, 4'h0, 1'b0, 4'h0, 8'h00));
    vecs.push_back(mk(4'h1, 4'h1, 1'b0, 4'h1, 8'h08));
    vecs.push_back(mk(4'hF, 4'hF, 1'b1, 4'h0, 8'h00));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 4'h2, 8'h49));

    // Reset held with requests pending and a non-empty FIFO.
    for (int c = 0; c < 2; c++) begin
      half();
      chk("rst_grant", 32'(req_grant), 32'h0);
      chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'h0);
      step_edge();
    end
    rst       = 1'b0;
    req_valid = '0;
    half();
    chk("post_rst_out_valid", 32'(out_valid), 32'h0);
    chk("post_rst_err", 32'(err_sticky), 32'h0);
    chk("post_rst_rd_en", 32'(fifo_rd_en), 32'h1);
    step_edge();

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);
    drain("drain_writes");

    // Read latency and output hold under backpressure.
    mem.push_back(8'h4A);
    exp_q.push_back(8'h4A);
    mem.push_back(8'h85);
    exp_q.push_back(8'h85);
    fifo_empty = 1'b0;
    half();
    chk("rd_t0_rd_en", 32'(fifo_rd_en), 32'h1);
    chk("rd_t0_valid", 32'(out_valid), 32'h0);
    step_edge();
    half();
    chk("rd_t1_rd_en", 32'(fifo_rd_en), 32'h0);
    chk("rd_t1_valid", 32'(out_valid), 32'h0);
    step_edge();
    half();
    chk("rd_t2_valid", 32'(out_valid), 32'h1);
    chk("rd_t2_id", 32'(out_id), 32'h1);
    chk("rd_t2_data", 32'(out_data), 32'h0A);
    chk("rd_t2_rd_en", 32'(fifo_rd_en), 32'h1);
    step_edge();
    half();
    chk("rd_t3_valid", 32'(out_valid), 32'h0);
    step_edge();
    half();
    chk("rd_t4_valid", 32'(out_valid), 32'h1);
    chk("rd_t4_id", 32'(out_id), 32'h2);
    chk("rd_t4_data", 32'(out_data), 32'h05);
    step_edge();

    out_ready = 1'b0;
    mem.push_back(8'h3F);
    exp_q.push_back(8'h3F);
    mem.push_back(8'hC1);
    exp_q.push_back(8'hC1);
    fifo_empty = 1'b0;
    half();
    step_edge();
    half();
    step_edge();
    for (int c = 0; c < 3; c++) begin
      half();
      chk("hold_valid", 32'(out_valid), 32'h1);
      chk("hold_id", 32'(out_id), 32'h0);
      chk("hold_data", 32'(out_data), 32'h3F);
      chk("hold_rd_en", 32'(fifo_rd_en), 32'h0);
      step_edge();
    end
    out_ready = 1'b1;
    half();
    chk("release_rd_en", 32'(fifo_rd_en), 32'h1);
    step_edge();
    drain("drain_reads");

    // Sticky error, then reset while a burst is locked.
    fifo_error = 1'b1;
    half();
    step_edge();
    fifo_error = 1'b0;
    half();
    chk("err_set", 32'(err_sticky), 32'h1);
    step_edge();
    half();
    step_edge();
    half();
    chk("err_hold", 32'(err_sticky), 32'h1);
    step_edge();
    req_valid = 4'h4;
    req_last  = 4'h0;
    half();
    chk("lock_grant", 32'(req_grant), 32'h4);
    step_edge();
    rst = 1'b1;
    half();
    chk("mid_rst_grant", 32'(req_grant), 32'h0);
    chk("mid_rst_wr_en", 32'(fifo_wr_en), 32'h0);
    step_edge();
    mem.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    rst        = 1'b0;
    req_valid  = 4'h5;
    req_last   = 4'h5;
    half();
    chk("after_rst_grant", 32'(req_grant), 32'h1);
    chk("after_rst_err", 32'(err_sticky), 32'h0);
    chk("after_rst_valid", 32'(out_valid), 32'h0);
    step_edge();
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
